// File: rtl/irq_src_pkg.sv
// Shared types and default sizes for the interrupt source controller.
// Optional drop statistics are enabled with IRQ_SRC_STATS_EN.
package irq_src_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } irq_state_e;

    localparam int DEF_N_IRQ = 32;
    localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/irq_source_ctrl_if.sv
// Peripheral/core interrupt bundle seen by irq_source_ctrl.
// Statistics signals exist only when IRQ_SRC_STATS_EN is defined.
interface irq_source_ctrl_if
    import irq_src_pkg::*;
#(
    parameter int N_IRQ = DEF_N_IRQ
`ifdef IRQ_SRC_STATS_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
);
    logic [N_IRQ-1:0] event_i;
    logic [N_IRQ-1:0] chan_en_i;
    logic [N_IRQ-1:0] edge_mode_i;
    logic [N_IRQ-1:0] int_fin_i;
    logic [N_IRQ-1:0] int_req_o;
`ifdef IRQ_SRC_STATS_EN
    logic             stats_clr_i;
    logic [N_IRQ*CNT_W-1:0] drop_cnt_o;

    modport master (output event_i, chan_en_i, edge_mode_i, int_fin_i, stats_clr_i,
                    input  int_req_o, drop_cnt_o);
    modport slave  (input  event_i, chan_en_i, edge_mode_i, int_fin_i, stats_clr_i,
                    output int_req_o, drop_cnt_o);
`else
    modport master (output event_i, chan_en_i, edge_mode_i, int_fin_i,
                    input  int_req_o);
    modport slave  (input  event_i, chan_en_i, edge_mode_i, int_fin_i,
                    output int_req_o);
`endif
endinterface

// File: rtl/irq_source_ctrl_channel.sv
// One interrupt line: IDLE/REQ/GAP handshake FSM, edge detector and replay flag.
// With IRQ_SRC_STATS_EN a saturating drop counter is added.
module irq_src_channel
    import irq_src_pkg::*;
`ifdef IRQ_SRC_STATS_EN
#(
    parameter int CNT_W = DEF_CNT_W
)
`endif
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_event,
    input  logic i_en,
    input  logic i_edge,
    input  logic i_fin,
`ifdef IRQ_SRC_STATS_EN
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
`endif
    output logic o_req
);
    irq_state_e r_state;
    logic       r_repeat;
    logic       r_event_q;
    logic       w_trig;
    logic       w_drop;

    assign w_trig = i_event & (~i_edge | ~r_event_q);
    // A second pending edge while one replay is already queued is lost.
    assign w_drop = i_en & i_edge & w_trig & r_repeat & (r_state == REQ);
    assign o_req  = (r_state == REQ);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_repeat  <= 1'b0;
            r_event_q <= 1'b0;
        end else begin
            r_event_q <= i_event;
            if (!i_en) begin
                r_state  <= IDLE;
                r_repeat <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (w_trig) r_state <= REQ;
                    REQ: begin
                        if (i_fin) r_state <= GAP;
                        if (i_edge && w_trig) r_repeat <= 1'b1;
                    end
                    GAP: begin
                        // An edge landing in GAP is queued and replayed like a pending repeat.
                        if (i_edge) begin
                            r_state  <= (r_repeat || w_trig) ? REQ : IDLE;
                            r_repeat <= r_repeat & w_trig;
                        end else begin
                            r_state  <= i_event ? REQ : IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

`ifdef IRQ_SRC_STATS_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            r_cnt <= '0;
        else if (w_drop && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;
`endif
endmodule

// File: rtl/irq_source_ctrl.sv
// Array of independent interrupt lines feeding the core int_req_i/int_fin_o handshake.
// Define IRQ_SRC_STATS_EN to add per-line drop counters and their clear.
module irq_source_ctrl
    import irq_src_pkg::*;
#(
    parameter int N_IRQ = DEF_N_IRQ
`ifdef IRQ_SRC_STATS_EN
    , parameter int CNT_W = DEF_CNT_W
`endif
)(
    input  logic                clk_i,
    input  logic                rst_i,
    irq_source_ctrl_if.slave    bus
);
    logic w_req [N_IRQ];
`ifdef IRQ_SRC_STATS_EN
    logic [CNT_W-1:0] w_cnt [N_IRQ];
`endif

    for (genvar g = 0; g < N_IRQ; g++) begin : g_chan
        irq_src_channel
`ifdef IRQ_SRC_STATS_EN
            #(.CNT_W(CNT_W))
`endif
        u_chan (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_event (bus.event_i[g]),
            .i_en    (bus.chan_en_i[g]),
            .i_edge  (bus.edge_mode_i[g]),
            .i_fin   (bus.int_fin_i[g]),
`ifdef IRQ_SRC_STATS_EN
            .i_clr   (bus.stats_clr_i),
            .o_cnt   (w_cnt[g]),
`endif
            .o_req   (w_req[g])
        );
    end

    always_comb begin
        bus.int_req_o = '0;
        for (int i = 0; i < N_IRQ; i++)
            bus.int_req_o[i] = w_req[i];
    end

`ifdef IRQ_SRC_STATS_EN
    always_comb begin
        bus.drop_cnt_o = '0;
        for (int i = 0; i < N_IRQ; i++)
            bus.drop_cnt_o[i*CNT_W +: CNT_W] = w_cnt[i];
    end
`endif
endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed bench for irq_source_ctrl: per-cycle vector table plus hand sequences.
// Counter checks are compiled in only with IRQ_SRC_STATS_EN.
module tb_irq_source_ctrl;
    import irq_src_pkg::*;

    localparam int N = 32;
    localparam logic [N-1:0] E  = 32'h0008_0000;   // line 19, edge
    localparam logic [N-1:0] L  = 32'h0000_0008;   // line 3, level
    localparam logic [N-1:0] F  = 32'h0000_0020;   // line 5, edge
    localparam logic [N-1:0] B  = 32'h8000_0001;   // lines 0 and 31

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irq_source_ctrl_if bus ();
    irq_source_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus.slave));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [N-1:0] ev;
        logic [N-1:0] fin;
        logic [N-1:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

`ifdef IRQ_SRC_STATS_EN
    task automatic chk_cnt(input string name, input int line, input int exp);
        logic [7:0] act;
        act = bus.drop_cnt_o[line*8 +: 8];
        n_cmp++;
        if (act !== exp[7:0]) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
`endif

    function automatic void addv(input logic [N-1:0] ev, input logic [N-1:0] fin,
                                 input logic [N-1:0] exp);
        vec_t v;
        v.ev = ev; v.fin = fin; v.exp = exp;
        tbl.push_back(v);
    endfunction

    initial begin
        // edge line 19: request, second edge queued, replay, retire
        addv(0, 0, 0);  addv(E, 0, E);  addv(E, 0, E);  addv(0, 0, E);
        addv(E, 0, E);  addv(0, E, 0);  addv(0, 0, E);  addv(0, E, 0);
        addv(0, 0, 0);  addv(0, 0, 0);
        // level line 3: re-raise across fin, then idle once event drops
        addv(L, 0, L);  addv(L, L, 0);  addv(L, 0, L);  addv(0, 0, L);
        addv(0, L, 0);  addv(0, 0, 0);  addv(0, 0, 0);
        // two-cycle fin retires only one request
        addv(L, 0, L);  addv(L, L, 0);  addv(L, L, L);  addv(0, 0, L);
        addv(0, L, 0);  addv(0, 0, 0);
        // edge coinciding with fin is still replayed
        addv(E, 0, E);  addv(0, 0, E);  addv(E, E, 0);  addv(E, 0, E);
        addv(0, E, 0);  addv(0, 0, 0);

        bus.event_i     = '0;
        bus.chan_en_i   = '0;
        bus.edge_mode_i = '0;
        bus.int_fin_i   = '0;
`ifdef IRQ_SRC_STATS_EN
        bus.stats_clr_i = 1'b0;
`endif
        rst = 1'b1;
        step(); step();
        chk("reset_req", bus.int_req_o, '0);
`ifdef IRQ_SRC_STATS_EN
        chk_cnt("reset_cnt", 19, 0);
`endif
        rst = 1'b0;
        bus.chan_en_i   = '1;
        bus.edge_mode_i = ~L;

        foreach (tbl[i]) begin
            bus.event_i   = tbl[i].ev;
            bus.int_fin_i = tbl[i].fin;
            step();
            chk($sformatf("vec%0d", i), bus.int_req_o, tbl[i].exp);
        end
        bus.event_i = '0; bus.int_fin_i = '0;
        step();

        // three edges in one request: one replay, one drop
        bus.event_i = E; step(); chk("drop_req", bus.int_req_o, E);
        bus.event_i = 0; step();
        bus.event_i = E; step();
        bus.event_i = 0; step();
        bus.event_i = E; step();
        bus.event_i = 0; step();
        chk("drop_hold", bus.int_req_o, E);
`ifdef IRQ_SRC_STATS_EN
        chk_cnt("drop_one", 19, 1);
`endif
        bus.int_fin_i = E; step(); chk("drop_gap", bus.int_req_o, 0);
        bus.int_fin_i = 0; step(); chk("drop_replay", bus.int_req_o, E);
        bus.event_i = E; step();
        bus.event_i = 0; step();
        for (int k = 0; k < 300; k++) begin
            bus.event_i = E; step();
            bus.event_i = 0; step();
        end
        chk("sat_req", bus.int_req_o, E);
`ifdef IRQ_SRC_STATS_EN
        chk_cnt("sat_255", 19, 255);
        bus.stats_clr_i = 1'b1;
`endif
        bus.event_i = E; step();
`ifdef IRQ_SRC_STATS_EN
        bus.stats_clr_i = 1'b0;
        chk_cnt("clr_wins", 19, 0);
`endif
        bus.event_i = 0; step();
        bus.event_i = E; step();
        bus.event_i = 0; step();
`ifdef IRQ_SRC_STATS_EN
        chk_cnt("after_clr", 19, 1);
`endif
        bus.int_fin_i = E; step(); chk("ret_gap", bus.int_req_o, 0);
        bus.int_fin_i = 0; step(); chk("ret_replay", bus.int_req_o, E);
        bus.int_fin_i = E; step(); chk("ret_gap2", bus.int_req_o, 0);
        bus.int_fin_i = 0; step(); chk("ret_idle", bus.int_req_o, 0);

        // disable withdraws; re-enable with line high gives no edge
        bus.event_i = F; step(); chk("en_req", bus.int_req_o, F);
        bus.chan_en_i = ~F; step(); chk("en_withdraw", bus.int_req_o, 0);
        step(); chk("en_off", bus.int_req_o, 0);
        bus.chan_en_i = '1; step(); chk("en_back", bus.int_req_o, 0);
        step(); chk("en_back2", bus.int_req_o, 0);
        bus.event_i = 0; step();

        // reset mid-request; later fins raise nothing
        bus.event_i = B; step(); chk("rst_pre", bus.int_req_o, B);
        bus.event_i = 0; rst = 1'b1; step(); chk("rst_drop", bus.int_req_o, 0);
        rst = 1'b0;
        bus.int_fin_i = B; step(); chk("rst_fin1", bus.int_req_o, 0);
        bus.int_fin_i = 0; step(); chk("rst_idle1", bus.int_req_o, 0);
        bus.int_fin_i = B; step(); chk("rst_fin2", bus.int_req_o, 0);
        bus.int_fin_i = 0; step(); chk("rst_idle2", bus.int_req_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
